// File: rtl/nic_if.sv
// rtl/nic_if.sv - CPU register window and router port bundle for the nic
//
// Purpose: groups the CPU-side register bus and the router-side packet
// handshake into one interface. The master modport is the environment
// (CPU and router); the slave modport is the nic itself.
// Signals:
//   addr, d_in, nicEn, nicWrEn  CPU -> nic register access
//   d_out                       nic -> CPU read data
//   net_si, net_di              router -> nic packet offer
//   net_ri                      nic -> router ingress ready
//   net_so, net_do              nic -> router packet send
//   net_ro, net_polarity        router -> nic egress ready and phase
// Data is big-endian: bit 0 is the MSB.
interface nic_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0]  addr;
  logic [0:DATA_WIDTH-1]  d_in;
  logic [0:DATA_WIDTH-1]  d_out;
  logic                   nicEn;
  logic                   nicWrEn;
  logic                   net_si;
  logic                   net_ri;
  logic [0:DATA_WIDTH-1]  net_di;
  logic                   net_so;
  logic                   net_ro;
  logic [0:DATA_WIDTH-1]  net_do;
  logic                   net_polarity;

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/nic.sv
// rtl/nic.sv - network interface controller between CPU and ring router
//
// Purpose: one-deep input and output packet buffers exposed to the CPU as
// four registers (00 input buffer, 01 input status, 10 output buffer,
// 11 output status), exchanged with the router by a ready/send handshake.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous active-high reset
//   bus    nic_if.slave: CPU register bus and router packet port
module nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic  clk,
  input  logic  reset,
  nic_if.slave  bus
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IN_BUF   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IN_STAT  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_BUF  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OUT_STAT = ADDR_WIDTH'(3);

  logic [0:DATA_WIDTH-1] r_in_buf;
  logic                  r_in_full;
  logic [0:DATA_WIDTH-1] r_out_buf;
  logic                  r_out_full;

  logic w_rd;
  logic w_wr;
  logic w_drain;
  logic w_load;
  logic w_ingress;
  logic w_send;

  assign w_rd      = bus.nicEn & ~bus.nicWrEn;
  assign w_wr      = bus.nicEn &  bus.nicWrEn;
  assign w_drain   = w_rd && (bus.addr == ADDR_IN_BUF) && r_in_full;
  // A write while the output buffer is still full is silently dropped.
  assign w_load    = w_wr && (bus.addr == ADDR_OUT_BUF) && !r_out_full;
  assign w_ingress = bus.net_si & ~r_in_full;
  // Bit 0 is the VC bit; inject only in the phase where that VC is idle.
  assign w_send    = r_out_full & bus.net_ro & (r_out_buf[0] == ~bus.net_polarity);

  assign bus.net_ri = ~r_in_full;
  assign bus.net_so = w_send;
  assign bus.net_do = r_out_buf;

  // Status words carry the full flag in bit DATA_WIDTH-1 (the LSB).
  always_comb begin
    bus.d_out = '0;
    if (w_rd) begin
      case (bus.addr)
        ADDR_IN_BUF:   bus.d_out = r_in_buf;
        ADDR_IN_STAT:  bus.d_out = {{(DATA_WIDTH-1){1'b0}}, r_in_full};
        ADDR_OUT_STAT: bus.d_out = {{(DATA_WIDTH-1){1'b0}}, r_out_full};
        default:       bus.d_out = '0;
      endcase
    end
  end

  // Ingress and drain are mutually exclusive (ingress needs empty, drain
  // needs full), as are load and send, so no priority is needed between them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_buf   <= '0;
      r_in_full  <= 1'b0;
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else begin
      if (w_ingress) begin
        r_in_buf  <= bus.net_di;
        r_in_full <= 1'b1;
      end else if (w_drain) begin
        r_in_full <= 1'b0;
      end
      if (w_send) begin
        r_out_full <= 1'b0;
      end else if (w_load) begin
        r_out_buf  <= bus.d_in;
        r_out_full <= 1'b1;
      end
    end
  end
endmodule
